// File: rtl/header_nonce_feeder_if.sv
// Handshake bundle between the header feeder, its template-word source and pre_mix.
// The slave modport is the feeder's view; master is the view of whoever drives it.
interface header_nonce_feeder_if #(
  parameter int HDR_W = 640
);
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      wr_data;
  logic             hdr_valid;
  logic             hdr_ready;
  logic [HDR_W-1:0] hdr_data;
  logic [31:0]      hdr_nonce;

  modport slave (
    input  wr_valid, wr_data, hdr_ready,
    output wr_ready, hdr_valid, hdr_data, hdr_nonce
  );

  modport master (
    output wr_valid, wr_data, hdr_ready,
    input  wr_ready, hdr_valid, hdr_data, hdr_nonce
  );
endinterface

// File: rtl/header_nonce_feeder.sv
// Holds a 19-word block-header template and sweeps a nonce range, emitting one
// full 640-bit header per nonce (nonce in the top word) toward pre_mix.
module header_nonce_feeder #(
  parameter int TMPL_WORDS = 19,
  parameter int HDR_W      = 32 * (TMPL_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  header_nonce_feeder_if.slave  bus,
  input  logic                  start,
  input  logic [31:0]           nonce_start,
  input  logic [31:0]           nonce_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done
);

  localparam int WCNT_W = $clog2(TMPL_WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(TMPL_WORDS - 1);

  typedef enum logic [1:0] {
    LOAD,
    ARMED,
    RUN
  } state_e;

  state_e                         state_q, state_d;
  logic [WCNT_W-1:0]              wcnt_q, wcnt_d;
  logic [TMPL_WORDS-1:0][31:0]    tmpl_q;
  logic                           tmpl_we;
  logic [31:0]                    nonce_q, nonce_d;
  logic [31:0]                    remaining_q, remaining_d;
  logic                           done_q, done_d;
  logic                           busy_q;

  // abort outranks everything; a header handshake in the same cycle still counts
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    nonce_d     = nonce_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    tmpl_we     = 1'b0;

    if (abort) begin
      state_d = LOAD;
      wcnt_d  = '0;
      if (state_q == RUN && bus.hdr_ready) begin
        nonce_d     = nonce_q + 32'd1;
        remaining_d = remaining_q - 32'd1;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.wr_valid) begin
            tmpl_we = 1'b1;
            if (wcnt_q == LAST_WORD) begin
              state_d = ARMED;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
        ARMED: begin
          if (start) begin
            if (nonce_count != 32'd0) begin
              nonce_d     = nonce_start;
              remaining_d = nonce_count;
              state_d     = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.hdr_ready) begin
            nonce_d     = nonce_q + 32'd1;
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
              state_d = ARMED;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wcnt_q      <= '0;
      tmpl_q      <= '0;
      nonce_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      nonce_q     <= nonce_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      busy_q      <= (state_d == RUN);
      if (tmpl_we) begin
        tmpl_q[wcnt_q] <= bus.wr_data;
      end
    end
  end

  // header is taken straight from the registers so it is stable under backpressure
  assign bus.wr_ready  = (state_q == LOAD);
  assign bus.hdr_valid = (state_q == RUN);
  assign bus.hdr_data  = HDR_W'({nonce_q, tmpl_q});
  assign bus.hdr_nonce = nonce_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_header_nonce_feeder.sv
// Randomised self-checking bench for header_nonce_feeder; expected headers come
// from a word-array template model plus a running nonce/remaining count.
module tb_header_nonce_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start;
  logic        abort;
  logic [31:0] nonce_start;
  logic [31:0] nonce_count;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  header_nonce_feeder_if #(.HDR_W(640)) bus();

  header_nonce_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .start       (start),
    .nonce_start (nonce_start),
    .nonce_count (nonce_count),
    .abort       (abort),
    .busy        (busy),
    .done        (done)
  );

  int          passCnt = 0;
  int          totalCnt = 0;
  logic [31:0] tmplModel [19];

  function automatic logic [639:0] expHeader(input logic [31:0] n);
    logic [639:0] h;
    h[639:608] = n;
    for (int k = 0; k < 19; k++) h[32*k +: 32] = tmplModel[k];
    return h;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gapMode: 0 = wr_valid always high, 1 = every other cycle, 2 = random gaps
  task automatic load_template(input int gapMode);
    int idx = 0;
    int cyc = 0;
    while (idx < 19 && cyc < 400) begin
      if (gapMode == 0)      bus.wr_valid = 1'b1;
      else if (gapMode == 1) bus.wr_valid = (cyc % 2 == 0);
      else                   bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_data = bus.wr_valid ? tmplModel[idx] : $urandom;
      totalCnt++;
      if (bus.wr_ready !== 1'b1)
        $display("[TB] FAIL load_wr_ready word=%0d got=%b exp=1", idx, bus.wr_ready);
      else passCnt++;
      tick;
      if (bus.wr_valid) idx++;
      cyc++;
    end
    bus.wr_valid = 1'b0;
    totalCnt++;
    if (idx != 19) $display("[TB] FAIL load_timeout words=%0d exp=19", idx);
    else passCnt++;
    totalCnt++;
    if ({bus.wr_ready, bus.hdr_valid, busy} !== 3'b000)
      $display("[TB] FAIL load_armed {wr_ready,hdr_valid,busy} got=%b exp=000",
               {bus.wr_ready, bus.hdr_valid, busy});
    else passCnt++;
  endtask

  // readyMode: 0 = hdr_ready high, 1 = low for 4 cycles then high, 2 = random
  task automatic run_sweep(input logic [31:0] ns, input logic [31:0] cnt,
                           input int readyMode, input bit wrNoise);
    logic [31:0] expN = ns;
    logic [31:0] rem = cnt;
    int          cyc = 0;
    nonce_start = ns;
    nonce_count = cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    nonce_start = $urandom;
    nonce_count = $urandom;
    while (rem != 0 && cyc < 500) begin
      if (readyMode == 0)      bus.hdr_ready = 1'b1;
      else if (readyMode == 1) bus.hdr_ready = (cyc >= 4);
      else                     bus.hdr_ready = 1'($urandom_range(0, 1));
      if (wrNoise) begin
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.wr_data  = $urandom;
      end
      totalCnt++;
      if ({bus.hdr_valid, done, busy, bus.hdr_nonce} !== {1'b1, 1'b0, 1'b1, expN})
        $display("[TB] FAIL sweep_ctrl {valid,done,busy,nonce} got=%b_%b_%b_%h exp=1_0_1_%h",
                 bus.hdr_valid, done, busy, bus.hdr_nonce, expN);
      else passCnt++;
      totalCnt++;
      if (bus.hdr_data !== expHeader(expN))
        $display("[TB] FAIL sweep_hdr_data nonce=%h got_lo=%h exp_lo=%h", expN,
                 bus.hdr_data[63:0], expHeader(expN) >> 0);
      else passCnt++;
      tick;
      if (bus.hdr_ready) begin
        expN++;
        rem--;
      end
      cyc++;
    end
    bus.hdr_ready = 1'b0;
    bus.wr_valid  = 1'b0;
    totalCnt++;
    if (rem != 0) $display("[TB] FAIL sweep_timeout remaining=%0d exp=0", rem);
    else passCnt++;
    totalCnt++;
    if ({bus.hdr_valid, done, busy} !== 3'b010)
      $display("[TB] FAIL sweep_done {valid,done,busy} got=%b exp=010",
               {bus.hdr_valid, done, busy});
    else passCnt++;
    tick;
    totalCnt++;
    if ({bus.hdr_valid, done} !== 2'b00)
      $display("[TB] FAIL sweep_done_pulse {valid,done} got=%b exp=00", {bus.hdr_valid, done});
    else passCnt++;
  endtask

  task automatic test_reset;
    #12;
    totalCnt++;
    if ({bus.wr_ready, bus.hdr_valid, busy, done} !== 4'b1000)
      $display("[TB] FAIL reset_ctrl got=%b exp=1000", {bus.wr_ready, bus.hdr_valid, busy, done});
    else passCnt++;
    totalCnt++;
    if (bus.hdr_data !== 640'd0 || bus.hdr_nonce !== 32'd0)
      $display("[TB] FAIL reset_data nonce got=%h exp=0", bus.hdr_nonce);
    else passCnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    for (int k = 0; k < 19; k++) tmplModel[k] = k;
    load_template(1);
    run_sweep(32'd5, 32'd3, 0, 1'b1);
    totalCnt++;
    if (bus.hdr_data[31:0] !== 32'd0 || bus.hdr_data[607:576] !== 32'h12)
      $display("[TB] FAIL basic_words w0=%h w18=%h exp=0/12",
               bus.hdr_data[31:0], bus.hdr_data[607:576]);
    else passCnt++;
  endtask

  task automatic test_backpressure;
    run_sweep(32'h100, 32'd2, 1, 1'b0);
  endtask

  task automatic test_wrap;
    run_sweep(32'hFFFF_FFFE, 32'd3, 0, 1'b0);
  endtask

  task automatic test_count_zero;
    nonce_start = $urandom;
    nonce_count = 32'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    totalCnt++;
    if ({bus.hdr_valid, done, busy} !== 3'b010)
      $display("[TB] FAIL zero_done {valid,done,busy} got=%b exp=010", {bus.hdr_valid, done, busy});
    else passCnt++;
    tick;
    totalCnt++;
    if ({bus.hdr_valid, done, bus.wr_ready} !== 3'b000)
      $display("[TB] FAIL zero_armed {valid,done,wr_ready} got=%b exp=000",
               {bus.hdr_valid, done, bus.wr_ready});
    else passCnt++;
    run_sweep($urandom, 32'd1, 0, 1'b0);
  endtask

  task automatic test_abort;
    logic [31:0] ns = $urandom;
    nonce_start = ns;
    nonce_count = 32'd10;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.hdr_ready = 1'b1;
      totalCnt++;
      if ({bus.hdr_valid, bus.hdr_nonce} !== {1'b1, ns + 32'(i)})
        $display("[TB] FAIL abort_hdr i=%0d got=%b_%h exp=1_%h", i, bus.hdr_valid,
                 bus.hdr_nonce, ns + 32'(i));
      else passCnt++;
      if (i == 3) abort = 1'b1;
      tick;
    end
    abort = 1'b0;
    bus.hdr_ready = 1'b0;
    totalCnt++;
    if ({bus.hdr_valid, done, busy, bus.wr_ready} !== 4'b0001)
      $display("[TB] FAIL abort_state {valid,done,busy,wr_ready} got=%b exp=0001",
               {bus.hdr_valid, done, busy, bus.wr_ready});
    else passCnt++;
    tick;
    totalCnt++;
    if (done !== 1'b0) $display("[TB] FAIL abort_no_done got=%b exp=0", done);
    else passCnt++;
    nonce_count = 32'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    totalCnt++;
    if ({bus.hdr_valid, bus.wr_ready} !== 2'b01)
      $display("[TB] FAIL abort_start_in_load {valid,wr_ready} got=%b exp=01",
               {bus.hdr_valid, bus.wr_ready});
    else passCnt++;
    for (int k = 0; k < 19; k++) tmplModel[k] = $urandom;
    load_template(2);
    run_sweep($urandom, 32'd2, 2, 1'b1);
    nonce_count = 32'd3;
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    totalCnt++;
    if ({bus.hdr_valid, busy, done, bus.wr_ready} !== 4'b0001)
      $display("[TB] FAIL abort_vs_start {valid,busy,done,wr_ready} got=%b exp=0001",
               {bus.hdr_valid, busy, done, bus.wr_ready});
    else passCnt++;
    load_template(0);
  endtask

  task automatic test_async_reset;
    nonce_start = $urandom;
    nonce_count = 32'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    bus.hdr_ready = 1'b1;
    tick;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    totalCnt++;
    if ({bus.hdr_valid, busy, done, bus.wr_ready} !== 4'b0001)
      $display("[TB] FAIL async_reset {valid,busy,done,wr_ready} got=%b exp=0001",
               {bus.hdr_valid, busy, done, bus.wr_ready});
    else passCnt++;
    totalCnt++;
    if (bus.hdr_data !== 640'd0) $display("[TB] FAIL async_reset_data nonce got=%h exp=0", bus.hdr_nonce);
    else passCnt++;
    #2;
    rst_n = 1'b1;
    bus.hdr_ready = 1'b0;
    for (int k = 0; k < 19; k++) tmplModel[k] = 32'd0;
    tick;
    nonce_count = 32'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    totalCnt++;
    if ({bus.hdr_valid, busy, bus.wr_ready} !== 3'b001)
      $display("[TB] FAIL async_start_ignored {valid,busy,wr_ready} got=%b exp=001",
               {bus.hdr_valid, busy, bus.wr_ready});
    else passCnt++;
    for (int k = 0; k < 19; k++) tmplModel[k] = $urandom;
    load_template(2);
    run_sweep($urandom, 32'd3, 2, 1'b1);
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      abort = 1'b1;
      tick;
      abort = 1'b0;
      totalCnt++;
      if (bus.wr_ready !== 1'b1) $display("[TB] FAIL random_reload_ready got=%b exp=1", bus.wr_ready);
      else passCnt++;
      for (int k = 0; k < 19; k++) tmplModel[k] = $urandom;
      load_template(2);
      for (int s = 0; s < 2; s++)
        run_sweep($urandom, 32'($urandom_range(1, 6)), 2, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    start         = 1'b0;
    abort         = 1'b0;
    nonce_start   = 32'd0;
    nonce_count   = 32'd0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 32'd0;
    bus.hdr_ready = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_count_zero;
    test_abort;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
